// File: rtl/mix_divider.sv
// rtl/mix_divider.sv - sign-magnitude radix-2^R restoring divider for MIX DIV
module mix_divider #(
  parameter int W = 30,
  parameter int R = 3
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic [2*W-1:0] c,
  input  logic           c_sign,
  input  logic [W-1:0]   a,
  input  logic           a_sign,
  output logic           busy,
  output logic           done,
  output logic           ovf,
  output logic [W-1:0]   b,
  output logic           b_sign,
  output logic [W-1:0]   rest,
  output logic           rest_sign
);

  localparam int N  = W / R;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * W + R + 1;
  localparam int K  = 1 << R;

  if (R < 1 || R > 4 || (W % R) != 0) begin : g_param_check
    $error("mix_divider: R must be in 1..4 and divide W");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_d;
  logic [2*W-1:0] p_q, d_q, p_next;
  logic [W-1:0]   q_q, q_next;
  logic [CW-1:0]  cnt_q;
  logic           c_sign_q, q_sign_q;
  logic [R-1:0]   k_sel;
  logic [PW-1:0]  diff;
  logic           ovf_detect, last;

  assign ovf_detect = c[2*W-1:W] >= a;
  assign last       = cnt_q == CW'(N - 1);
  assign busy       = state_q == RUN;
  assign q_next     = (q_q << R) | W'(k_sel);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !ovf_detect) state_d = RUN;
      RUN:     if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A non-negative difference never exceeds P, so its bits above 2W are all
  // zero exactly when the subtraction did not go negative.
  always_comb begin
    k_sel  = '0;
    p_next = p_q;
    diff   = '0;
    for (int k = 1; k < K; k++) begin
      diff = PW'(p_q) - PW'(k) * PW'(d_q);
      if (diff[PW-1:2*W] == '0) begin
        k_sel  = R'(k);
        p_next = diff[2*W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      p_q       <= '0;
      d_q       <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      c_sign_q  <= 1'b0;
      q_sign_q  <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      b         <= '0;
      b_sign    <= 1'b0;
      rest      <= '0;
      rest_sign <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (ovf_detect) begin
              done <= 1'b1;
              ovf  <= 1'b1;
            end else begin
              ovf      <= 1'b0;
              p_q      <= c;
              d_q      <= {{W{1'b0}}, a} << (W - R);
              q_q      <= '0;
              cnt_q    <= '0;
              c_sign_q <= c_sign;
              q_sign_q <= c_sign ^ a_sign;
            end
          end
        end
        RUN: begin
          p_q   <= p_next;
          q_q   <= q_next;
          d_q   <= d_q >> R;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            done      <= 1'b1;
            b         <= q_next;
            rest      <= p_next[W-1:0];
            b_sign    <= q_sign_q;
            rest_sign <= c_sign_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
